// File: rtl/uart_apb_arbiter.sv
// Two-requester round-robin APB master for the UART register block.
// Writes to the TX data register are paced by a gap counter.
module uart_apb_arbiter #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TX_ADDR = 0,
    parameter int unsigned TX_GAP  = 104160
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              pSel,
    output logic              pEnable,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddr,
    output logic [DATA_W-1:0] pWdata,
    input  logic [DATA_W-1:0] pReadData,
    output logic              tx_gap_busy
);

    localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LD = GW'(TX_GAP);
    localparam logic [ADDR_W-1:0] TXA = ADDR_W'(TX_ADDR);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ACK    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              elig0, elig1, pick;

    assign tx_gap_busy = (gap_q != '0);

    // A TX-data write is only held back while the pacing window is open
    assign elig0 = req0 && !(wr0 && addr0 == TXA && tx_gap_busy);
    assign elig1 = req1 && !(wr1 && addr1 == TXA && tx_gap_busy);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        gap_d    = tx_gap_busy ? gap_q - 1'b1 : '0;
        pick     = (elig0 && elig1) ? ~grant_q : elig1;
        case (state_q)
            ST_IDLE: begin
                if (elig0 || elig1) begin
                    grant_d  = pick;
                    pwrite_d = pick ? wr1 : wr0;
                    paddr_d  = pick ? addr1 : addr0;
                    pwdata_d = pick ? wdata1 : wdata0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (!pwrite_q) begin
                    rdata_d = pReadData;
                end else if (paddr_q == TXA) begin
                    gap_d = GAP_LD;
                end
                pwdata_d = '0;
                state_d  = ST_ACK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b1;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            gap_q    <= gap_d;
        end
    end

    assign pSel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign pEnable = (state_q == ST_ACCESS);
    assign pWrite  = pwrite_q;
    assign pAddr   = paddr_q;
    assign pWdata  = pwdata_q;
    assign rdata   = rdata_q;
    assign ack0    = (state_q == ST_ACK) && !grant_q;
    assign ack1    = (state_q == ST_ACK) && grant_q;

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Randomized two-requester bench with a transfer-level reference model
// and a cycle-accurate scoreboard on the APB and ack outputs.
module tb_uart_apb_arbiter;

    localparam int GAP = 20;

    logic        pClk = 1'b0;
    logic        pReset;
    logic [1:0]  req_v;
    logic [1:0]  wr_v;
    logic [31:0] addr_v [2];
    logic [31:0] wdata_v [2];
    logic        ack0, ack1, pSel, pEnable, pWrite, tx_gap_busy;
    logic [31:0] rdata, pAddr, pWdata, pReadData;

    uart_apb_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TX_ADDR(0), .TX_GAP(GAP)
    ) dut (
        .pClk(pClk), .pReset(pReset),
        .req0(req_v[0]), .wr0(wr_v[0]), .addr0(addr_v[0]),
        .wdata0(wdata_v[0]), .ack0(ack0),
        .req1(req_v[1]), .wr1(wr_v[1]), .addr1(addr_v[1]),
        .wdata1(wdata_v[1]), .ack1(ack1),
        .rdata(rdata), .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite),
        .pAddr(pAddr), .pWdata(pWdata), .pReadData(pReadData),
        .tx_gap_busy(tx_gap_busy)
    );

    always #5 pClk = ~pClk;

    typedef struct {
        int          s;
        bit          who;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
    } xfer_t;

    xfer_t       q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          free_at = 0;
    int          tx_ok_at = 0;
    bit          lg = 1'b1;
    bit          in_reset = 1'b1;
    bit          checking = 1'b0;
    bit          run = 1'b0;
    logic [1:0]  done = 2'b00;
    logic [31:0] smem [16];
    logic [31:0] rmem [16];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 32'd0;
            2:       return 32'd3;
            default: return 32'd7;
        endcase
    endfunction

    always @(posedge pClk) cyc <= cyc + 1;

    // Stand-in UART register block: junk outside ACCESS
    initial begin
        pReadData = '0;
        forever begin
            @(posedge pClk);
            #2;
            pReadData = (pSel && pEnable) ? smem[pAddr[3:0]] : $urandom;
        end
    end

    always @(negedge pClk)
        if (pSel && pEnable && pWrite) smem[pAddr[3:0]] = pWdata;

    // Reference model: one transfer per 4 cycles, TX writes spaced by GAP
    always @(negedge pClk) begin
        bit    e [2];
        bit    p;
        xfer_t x;
        #1;
        if (!in_reset && checking && cyc >= free_at) begin
            for (int n = 0; n < 2; n++)
                e[n] = req_v[n] && !(wr_v[n] && addr_v[n] == 0
                                     && cyc < tx_ok_at);
            if (e[0] || e[1]) begin
                p = (e[0] && e[1]) ? !lg : e[1];
                lg = p;
                x.s = cyc + 1;
                x.who = p;
                x.wr = wr_v[p];
                x.addr = addr_v[p];
                x.wdata = wdata_v[p];
                x.rd = rmem[addr_v[p][3:0]];
                if (x.wr) rmem[x.addr[3:0]] = x.wdata;
                if (x.wr && x.addr == 0) tx_ok_at = cyc + GAP + 3;
                free_at = cyc + 4;
                q.push_back(x);
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge pClk) begin
        bit eb;
        if (!in_reset && checking) begin
            eb = (cyc >= tx_ok_at - GAP) && (cyc < tx_ok_at);
            chk("gap_busy", tx_gap_busy, eb);
            if (q.size() > 0 && cyc == q[0].s) begin
                chk("setup", {pSel, pEnable, pWrite, pAddr, pWdata},
                    {2'b10, q[0].wr, q[0].addr, q[0].wdata});
            end else if (q.size() > 0 && cyc == q[0].s + 1) begin
                chk("access", {pSel, pEnable, pWrite, pAddr, pWdata},
                    {2'b11, q[0].wr, q[0].addr, q[0].wdata});
            end else if (q.size() > 0 && cyc == q[0].s + 2) begin
                chk("ack", {pSel, pEnable, ack0, ack1, pWdata},
                    {2'b00, !q[0].who, q[0].who, 32'h0});
                if (!q[0].wr) chk("rdata", rdata, q[0].rd);
                void'(q.pop_front());
            end else begin
                chk("idle", {pSel, pEnable, ack0, ack1}, 4'b0000);
            end
        end
    end

    task automatic drive(input int n);
        bit got;
        @(posedge pClk);
        #1;
        while (run) begin
            wr_v[n] = 1'($urandom_range(0, 1));
            addr_v[n] = pick_addr();
            wdata_v[n] = $urandom;
            req_v[n] = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 600 && !got; t++) begin
                @(negedge pClk);
                got = n ? ack1 : ack0;
            end
            chk("ack_seen", got, 1'b1);
            @(posedge pClk);
            #1;
            if ($urandom_range(0, 2) != 0) begin
                req_v[n] = 1'b0;
                repeat ($urandom_range(0, 5)) @(posedge pClk);
                #1;
            end
        end
        req_v[n] = 1'b0;
        done[n] = 1'b1;
    endtask

    initial begin
        for (int n = 0; n < 16; n++) begin
            smem[n] = $urandom;
            rmem[n] = smem[n];
        end
        req_v = '0;
        wr_v = '0;
        addr_v[0] = '0;
        addr_v[1] = '0;
        wdata_v[0] = '0;
        wdata_v[1] = '0;
        pReset = 1'b0;
        repeat (3) @(posedge pClk);
        #3;
        pReset = 1'b1;
        free_at = cyc;
        tx_ok_at = 0;
        lg = 1'b1;
        in_reset = 1'b0;
        checking = 1'b1;
        repeat (20) @(posedge pClk);
        run = 1'b1;
        fork
            drive(0);
            drive(1);
        join_none
        repeat (800) @(posedge pClk);
        begin : find_access
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 400 && !seen; t++) begin
                @(negedge pClk);
                seen = pSel && pEnable;
            end
            chk("access_found", seen, 1'b1);
        end
        #1;
        in_reset = 1'b1;
        pReset = 1'b0;
        #1;
        chk("rst_async", {pSel, pEnable, ack0, ack1, tx_gap_busy}, 5'b0);
        repeat (2) begin
            @(negedge pClk);
            chk("rst_hold", {pSel, pEnable, ack0, ack1}, 4'b0);
        end
        @(posedge pClk);
        #3;
        q.delete();
        pReset = 1'b1;
        free_at = cyc;
        tx_ok_at = 0;
        lg = 1'b1;
        in_reset = 1'b0;
        repeat (400) @(posedge pClk);
        run = 1'b0;
        for (int t = 0; t < 2000 && done != 2'b11; t++) @(posedge pClk);
        chk("drain", done, 2'b11);
        repeat (30) @(posedge pClk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_apb_arbiter.md
Name: uart_apb_arbiter

Overview:
- Arbitrates between two requesters (e.g. CPU core and DMA/test sequencer) that share the UART register block's APB slave port.
- Acts as the only APB master toward the UART register block.
- Converts each requester's simple req/ack handshake into a two-phase APB transfer (setup, then access). Grants requesters round-robin.
- Paces writes to the TX data register so that consecutive TX bytes are spaced by at least one UART frame. The UART block provides no pReady or busy flag, so this pacing is required.

Parameters:
- ADDR_W, 32, width of address buses.
- DATA_W, 32, width of data buses.
- TX_ADDR, 0, UART register address of the TX data register.
- TX_GAP, 104160, minimum idle cycles after a TX-data write before the next one may start (10 bits × 10416 clk at 9600 baud, 100 MHz).

Ports:
- pClk  in  1  system clock; all logic is on the rising edge.
- pReset  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 transfer request; held high until ack0.
- wr0  in  1  requester 0 direction; 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 register address.
- wdata0  in  DATA_W  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, wr1, addr1, wdata1, ack1: same as above, for requester 1.
- rdata  out  DATA_W  read data; valid in the ack cycle.
- pSel  out  1  APB select to the UART register block.
- pEnable  out  1  APB enable.
- pWrite  out  1  APB direction.
- pAddr  out  ADDR_W  APB address.
- pWdata  out  DATA_W  APB write data.
- pReadData  in  DATA_W  APB read data from the UART register block.
- tx_gap_busy  out  1  high while the TX pacing counter is non-zero.

Behaviour:
- Reset (pReset=0, asynchronous): state=IDLE; all outputs 0; gap_cnt=0; last_grant=1, so requester 0 wins the first tie. A reset asserted mid-transfer drops pSel/pEnable immediately, and no ack is issued.
- FSM states: IDLE, SETUP, ACCESS, ACK.
- Eligibility: reqN=1 AND NOT (wrN=1 AND addrN==TX_ADDR AND gap_cnt!=0). Reads of TX_ADDR are never blocked.
- IDLE:
  - If no requester is eligible, stay in IDLE with pSel=0.
  - Otherwise grant one requester. If both are eligible, grant the one that is not last_grant.
  - Register the granted wr/addr/wdata into pWrite/pAddr/pWdata, update last_grant, and go to SETUP.
- SETUP: pSel=1, pEnable=0. Next state is ACCESS.
- ACCESS: pSel=1, pEnable=1.
  - For a read, capture pReadData into rdata at the end of this cycle.
  - For a write to TX_ADDR, load gap_cnt=TX_GAP at the end of this cycle.
  - Next state is ACK.
- ACK: pSel=0, pEnable=0, pWdata=0. ackN=1 for the granted requester only; rdata is valid. Next state is IDLE.
- Latency: from req sampled in IDLE to ack is 3 cycles (SETUP, ACCESS, ACK). Back-to-back transfers occupy 4 cycles each.
- Requester rules:
  - Hold req, wr, addr and wdata stable until ack.
  - Drop req on the edge that ends the ack cycle. If req is still high in the following IDLE cycle, it is treated as a new transfer with the current fields.
- Address/data: pAddr/pWrite/pWdata are held constant from SETUP through ACCESS. rdata holds its last read value until the next read completes.
- Gap counter:
  - Decrements by 1 each cycle while non-zero; saturates at 0.
  - A reload in ACCESS overrides the decrement.
  - tx_gap_busy = (gap_cnt != 0).
  - Result: the next TX write's SETUP occurs at least TX_GAP+1 cycles after the previous TX write's ACCESS cycle.
- No head-of-line blocking: a requester blocked by the gap does not stall the other requester's transfers. A blocked requester keeps its round-robin priority; last_grant is unchanged by blocked cycles.
- Requests that arrive while the FSM is not in IDLE wait. They are evaluated in the next IDLE cycle.

Test Plan:
- Reset release, no requests -> pSel=pEnable=0, ack0=ack1=0, tx_gap_busy=0 for 20 cycles.
- req0 write addr=3 data=0x2 -> SETUP with pSel=1, pAddr=3, pWdata=2; next cycle pEnable=1; next cycle ack0=1; gap_cnt stays 0.
- TX_GAP=20: req0 writes TX data 10, then TX data 15 immediately after ack -> second SETUP at least 21 cycles after first ACCESS; tx_gap_busy high for exactly 20 cycles.
- req0 and req1 both request reads at addr 3 (pReadData=0x55 in both ACCESS cycles), held continuously -> grants alternate 0,1,0,1; each ack carries rdata=0x55; 4 cycles per transfer.
- TX_GAP=20: req0 TX write blocked by gap while req1 reads addr 3 -> req1 completes during the gap; req0 starts once gap_cnt reaches 0.
- pReset pulled low during ACCESS -> pSel/pEnable go 0 asynchronously, no ack; after release, a held req0 restarts from SETUP.
